// File: rtl/set_pkg.sv
// Shared widths, SET mode encodings and sequencer state type.
package set_pkg;

  localparam int unsigned CENTRAL_W = 24;
  localparam int unsigned RADIUS_W  = 12;
  localparam int unsigned CAND_W    = 8;
  localparam int unsigned MODE_W    = 2;
  localparam int unsigned ERR_W     = 7;

  localparam logic [MODE_W-1:0] MODE_SINGLE = 2'b00;
  localparam logic [MODE_W-1:0] MODE_UNION  = 2'b01;
  localparam logic [MODE_W-1:0] MODE_DIFF   = 2'b10;
  localparam logic [MODE_W-1:0] MODE_INTER  = 2'b11;

  typedef enum logic [3:0] {
    IDLE,
    RD,
    LD,
    WAIT_BUSY,
    ISSUE,
    WAIT_VALID,
    CHECK,
    NEXT,
    DONE
  } state_e;

  // Error counter increment that sticks at all-ones.
  function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] v);
    return (v == {ERR_W{1'b1}}) ? v : v + ERR_W'(1);
  endfunction

endpackage

// File: rtl/set_resp_timer.sv
// Clearable up-counter that flags when it has reached TIMEOUT_CYC-1.
module set_resp_timer #(
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up and hold at the last value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LastCnt)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == LastCnt);

endmodule

// File: rtl/set_host_seq.sv
// Self-test initiator for SET: walks the pattern ROM, issues one request per
// entry and scores the returned candidates.
module set_host_seq
  import set_pkg::*;
#(
  parameter int unsigned NUM_PAT     = 64,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned MAX_ERR     = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [MODE_W-1:0]    mode_sel,
  output logic [ADDR_W-1:0]    pat_addr,
  input  logic [CENTRAL_W-1:0] rom_central,
  input  logic [RADIUS_W-1:0]  rom_radius,
  input  logic [CAND_W-1:0]    rom_expected,
  input  logic                 busy,
  input  logic                 valid,
  input  logic [CAND_W-1:0]    candidate,
  output logic                 en,
  output logic [CENTRAL_W-1:0] central,
  output logic [RADIUS_W-1:0]  radius,
  output logic [MODE_W-1:0]    mode,
  output logic                 done,
  output logic                 pass,
  output logic                 aborted,
  output logic [ERR_W-1:0]     err_cnt,
  output logic [ADDR_W-1:0]    first_fail,
  output logic                 timeout_seen
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_PAT - 1);
  localparam logic [ERR_W-1:0]  MaxErr  = ERR_W'(MAX_ERR);

  state_e               state_q, state_d;
  logic [MODE_W-1:0]    mode_q, mode_d;
  logic [ADDR_W-1:0]    idx_q, idx_d;
  logic [CENTRAL_W-1:0] central_q, central_d;
  logic [RADIUS_W-1:0]  radius_q, radius_d;
  logic [CAND_W-1:0]    exp_q, exp_d;
  logic [CAND_W-1:0]    cand_q, cand_d;
  logic                 en_q, en_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 aborted_q, aborted_d;
  logic [ERR_W-1:0]     err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]    first_fail_q, first_fail_d;
  logic                 timeout_seen_q, timeout_seen_d;
  logic                 tmr_expire;

  // Response watchdog: restarted in ISSUE, runs only while waiting for valid.
  set_resp_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_resp_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_q == ISSUE),
    .inc   (state_q == WAIT_VALID),
    .expire(tmr_expire)
  );

  // Next-state and status update for the pattern walk.
  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    idx_d          = idx_q;
    central_d      = central_q;
    radius_d       = radius_q;
    exp_d          = exp_q;
    cand_d         = cand_q;
    done_d         = done_q;
    pass_d         = pass_q;
    aborted_d      = aborted_q;
    err_cnt_d      = err_cnt_q;
    first_fail_d   = first_fail_q;
    timeout_seen_d = timeout_seen_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d         = mode_sel;
          err_cnt_d      = '0;
          first_fail_d   = '0;
          done_d         = 1'b0;
          pass_d         = 1'b0;
          aborted_d      = 1'b0;
          timeout_seen_d = 1'b0;
          idx_d          = '0;
          state_d        = RD;
        end
      end
      RD: begin
        state_d = LD;
      end
      LD: begin
        central_d = rom_central;
        radius_d  = rom_radius;
        exp_d     = rom_expected;
        state_d   = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!busy) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT_VALID;
      end
      WAIT_VALID: begin
        // A response in the expiry cycle still counts as a response.
        if (valid) begin
          cand_d  = candidate;
          state_d = CHECK;
        end else if (tmr_expire) begin
          timeout_seen_d = 1'b1;
          err_cnt_d      = err_sat_inc(err_cnt_q);
          if (err_cnt_q == '0) begin
            first_fail_d = idx_q;
          end
          state_d = NEXT;
        end
      end
      CHECK: begin
        if (cand_q != exp_q) begin
          err_cnt_d = err_sat_inc(err_cnt_q);
          if (err_cnt_q == '0) begin
            first_fail_d = idx_q;
          end
        end
        state_d = NEXT;
      end
      NEXT: begin
        if (err_cnt_q >= MaxErr) begin
          aborted_d = 1'b1;
          state_d   = DONE;
        end else if (idx_q == LastIdx) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = RD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered strobes track the state being entered.
    en_d = (state_d == ISSUE);
    if (state_d == DONE) begin
      done_d = 1'b1;
      pass_d = (err_cnt_q == '0);
    end
  end

  // State and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      mode_q         <= '0;
      idx_q          <= '0;
      central_q      <= '0;
      radius_q       <= '0;
      exp_q          <= '0;
      cand_q         <= '0;
      en_q           <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      aborted_q      <= 1'b0;
      err_cnt_q      <= '0;
      first_fail_q   <= '0;
      timeout_seen_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      idx_q          <= idx_d;
      central_q      <= central_d;
      radius_q       <= radius_d;
      exp_q          <= exp_d;
      cand_q         <= cand_d;
      en_q           <= en_d;
      done_q         <= done_d;
      pass_q         <= pass_d;
      aborted_q      <= aborted_d;
      err_cnt_q      <= err_cnt_d;
      first_fail_q   <= first_fail_d;
      timeout_seen_q <= timeout_seen_d;
    end
  end

  assign pat_addr     = idx_q;
  assign en           = en_q;
  assign central      = central_q;
  assign radius       = radius_q;
  assign mode         = mode_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign aborted      = aborted_q;
  assign err_cnt      = err_cnt_q;
  assign first_fail   = first_fail_q;
  assign timeout_seen = timeout_seen_q;

endmodule

// File: tb/tb_set_host_seq.sv
// Bench for set_host_seq: ROM model, behavioural SET responder and a
// run-level scoreboard predicting issue timing and final status.
module tb_set_host_seq;
  import set_pkg::*;

  localparam int NP = 64;
  localparam int TO = 16;
  localparam int ME = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode_sel = 2'b00;
  logic [5:0]  pat_addr;
  logic [23:0] rom_central = '0;
  logic [11:0] rom_radius = '0;
  logic [7:0]  rom_expected = '0;
  logic        busy = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  candidate = '0;
  logic        en, done, pass, aborted, timeout_seen;
  logic [23:0] central;
  logic [11:0] radius;
  logic [1:0]  mode;
  logic [6:0]  err_cnt;
  logic [5:0]  first_fail;

  set_host_seq #(
    .NUM_PAT(NP), .ADDR_W(6), .TIMEOUT_CYC(TO), .MAX_ERR(ME)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode_sel(mode_sel), .pat_addr(pat_addr),
    .rom_central(rom_central), .rom_radius(rom_radius), .rom_expected(rom_expected),
    .busy(busy), .valid(valid), .candidate(candidate), .en(en), .central(central),
    .radius(radius), .mode(mode), .done(done), .pass(pass), .aborted(aborted),
    .err_cnt(err_cnt), .first_fail(first_fail), .timeout_seen(timeout_seen)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Test configuration: ROM contents, what SET returns, response delay (0 = never).
  logic [23:0] rom_c[NP];
  logic [11:0] rom_r[NP];
  logic [7:0]  rom_e[NP];
  logic [7:0]  ret_c[NP];
  int          resp_d[NP];
  bit          stray_on = 1'b0;
  int          pre_busy_end = -1;

  function automatic logic [7:0] good_cand(input int i);
    return 8'(i * 29 + 3);
  endfunction

  task automatic load_defaults();
    for (int i = 0; i < NP; i++) begin
      rom_c[i]  = 24'(i * 24'h010203) ^ 24'hA5A5A5;
      rom_r[i]  = 12'(i * 19 + 7);
      rom_e[i]  = good_cand(i);
      ret_c[i]  = good_cand(i);
      resp_d[i] = 6;
    end
    stray_on = 1'b0;
  endtask

  // Registered ROM: data follows pat_addr by one cycle.
  always @(posedge clk) begin
    rom_central  <= rom_c[pat_addr];
    rom_radius   <= rom_r[pat_addr];
    rom_expected <= rom_e[pat_addr];
  end

  // SET responder: busy for 3 cycles after en, valid resp_d cycles after en.
  int         last_en = -100;
  int         resp_at = -1;
  logic [7:0] resp_val = '0;
  int         rk = 0;
  always @(negedge clk) begin
    if (rst && en) begin
      last_en  = cyc;
      resp_at  = (rk < NP && resp_d[rk] != 0) ? cyc + resp_d[rk] : -1;
      resp_val = (rk < NP) ? ret_c[rk] : 8'h00;
      rk++;
    end
    busy      = ((cyc > last_en) && (cyc <= last_en + 3)) || (cyc <= pre_busy_end);
    valid     = (cyc == resp_at) || (stray_on && (cyc == last_en + 8));
    candidate = (cyc == resp_at) ? resp_val : 8'hEE;
  end

  // Run-level model: predicts each issue cycle, its data and the final status.
  bit         run_on = 1'b0;
  bit         run_done = 1'b0;
  int         start_c;
  int         exp_en, exp_done;
  int         mk;
  int         m_err, m_first;
  bit         m_abort, m_to;
  logic [1:0] m_mode;
  int         en_at[NP];

  always @(negedge clk) begin
    if (run_on) begin
      chk("en", en, cyc == exp_en);
      if (cyc == exp_en) begin
        int next_c;
        bit bad;
        chk("central", central, rom_c[mk]);
        chk("radius", radius, rom_r[mk]);
        chk("mode", mode, m_mode);
        en_at[mk] = cyc;
        if (resp_d[mk] >= 1 && resp_d[mk] <= TO) begin
          bad    = (ret_c[mk] != rom_e[mk]);
          next_c = cyc + resp_d[mk] + 2;  // scored cycle, then CHECK, then NEXT
        end else begin
          bad    = 1'b1;
          m_to   = 1'b1;
          next_c = cyc + TO + 1;          // expiry TO cycles after en, then NEXT
        end
        if (bad) begin
          if (m_err == 0) m_first = mk;
          if (m_err < 127) m_err++;
        end
        if (m_err >= ME) begin
          m_abort  = 1'b1;
          exp_done = next_c + 1;
          exp_en   = -1;
        end else if (mk == NP - 1) begin
          exp_done = next_c + 1;
          exp_en   = -1;
        end else begin
          exp_en = next_c + 4;            // RD, LD, WAIT_BUSY, ISSUE
        end
        mk++;
      end
      chk("done", done, cyc >= exp_done);
      if (cyc == exp_done) begin
        chk("pass", pass, m_err == 0);
        chk("err_cnt", err_cnt, m_err);
        chk("first_fail", first_fail, m_first);
        chk("aborted", aborted, m_abort);
        chk("timeout_seen", timeout_seen, m_to);
        run_on   = 1'b0;
        run_done = 1'b1;
      end
    end
  end

  task automatic begin_run(input logic [1:0] ms, input int busy_pre);
    @(negedge clk); #1;
    rk = 0; last_en = -100; resp_at = -1;
    pre_busy_end = (busy_pre > 0) ? cyc + busy_pre : -1;
    mk = 0; m_err = 0; m_first = 0; m_abort = 1'b0; m_to = 1'b0; m_mode = ms;
    exp_done = 1 << 30; run_done = 1'b0;
    mode_sel = ms;
    @(negedge clk); #1;
    start   = 1'b1;
    start_c = cyc;
    exp_en  = (start_c + 4 > pre_busy_end + 2) ? start_c + 4 : pre_busy_end + 2;
    @(negedge clk); #1;
    start  = 1'b0;
    run_on = 1'b1;
  endtask

  task automatic finish_run(input string name);
    for (int i = 0; i < 3000 && !run_done; i++) @(negedge clk);
    if (!run_done) begin
      n_chk++; n_fail++;
      $display("FAIL %s: run did not reach done within 3000 cycles", name);
      run_on = 1'b0;
    end
    repeat (5) @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    load_defaults();
    #3 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_en", en, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err_cnt", err_cnt, 7'd0);
    chk("rst_pat_addr", pat_addr, 6'd0);
    #1 rst = 1'b1;

    // 1: all match, union mode, a stray valid outside WAIT_VALID each pattern.
    load_defaults();
    stray_on = 1'b1;
    begin_run(MODE_UNION, 0);
    finish_run("t1");
    chk("t1_pass", pass, 1'b1);
    chk("t1_done", done, 1'b1);
    chk("t1_err", err_cnt, 7'd0);
    chk("t1_en_pulses", rk, 64);
    chk("t1_mode", mode, 2'b01);
    chk("t1_first_en", en_at[0] - start_c, 4);
    chk("t1_en_spacing", en_at[1] - en_at[0], 12);

    // 2: two bad ROM expectations.
    load_defaults();
    rom_e[5]  = rom_e[5] ^ 8'h55;
    rom_e[40] = rom_e[40] ^ 8'h01;
    begin_run(MODE_SINGLE, 0);
    finish_run("t2");
    chk("t2_err", err_cnt, 7'd2);
    chk("t2_first", first_fail, 6'd5);
    chk("t2_pass", pass, 1'b0);
    chk("t2_aborted", aborted, 1'b0);
    chk("t2_en_pulses", rk, 64);

    // 3: wrong candidates from entry 3 on -> abort after entry 12.
    load_defaults();
    for (int i = 3; i < NP; i++) ret_c[i] = ~good_cand(i);
    begin_run(MODE_DIFF, 0);
    finish_run("t3");
    chk("t3_aborted", aborted, 1'b1);
    chk("t3_err", err_cnt, 7'd10);
    chk("t3_first", first_fail, 6'd3);
    chk("t3_done", done, 1'b1);
    chk("t3_en_pulses", rk, 13);

    // 4: entry 7 never answered.
    load_defaults();
    resp_d[7] = 0;
    begin_run(MODE_INTER, 0);
    finish_run("t4");
    chk("t4_timeout", timeout_seen, 1'b1);
    chk("t4_err", err_cnt, 7'd1);
    chk("t4_first", first_fail, 6'd7);
    // Timeout declared 16 cycles after en, then NEXT, RD, LD, WAIT_BUSY, ISSUE.
    chk("t4_gap", en_at[8] - en_at[7], 21);

    // 5: busy for 20 cycles from start; entry 0 answered on the final count.
    load_defaults();
    resp_d[0] = TO;
    begin_run(MODE_UNION, 20);
    finish_run("t5");
    chk("t5_timeout", timeout_seen, 1'b0);
    chk("t5_pass", pass, 1'b1);
    chk("t5_first_en", en_at[0] - start_c, 21);

    // 6: asynchronous reset in WAIT_VALID of entry 30, then a clean rerun.
    load_defaults();
    begin_run(MODE_DIFF, 0);
    for (int i = 0; i < 2000 && mk < 31; i++) @(negedge clk);
    chk("t6_reached_30", mk, 31);
    @(negedge clk);
    @(negedge clk);
    #2;
    run_on = 1'b0;
    rst = 1'b0;
    #1;
    chk("t6_rst_en", en, 1'b0);
    chk("t6_rst_central", central, 24'd0);
    chk("t6_rst_radius", radius, 12'd0);
    chk("t6_rst_mode", mode, 2'b00);
    chk("t6_rst_pat_addr", pat_addr, 6'd0);
    chk("t6_rst_status", {done, pass, aborted, timeout_seen}, 4'd0);
    chk("t6_rst_err", {err_cnt, first_fail}, 13'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    begin_run(MODE_UNION, 0);
    finish_run("t6");
    chk("t6_pass", pass, 1'b1);
    chk("t6_en_pulses", rk, 64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
